// File: rtl/filter_buf_loader.sv
// Filter-buffer loader: on a CSYNC load request, streams one output-channel tile
// of filter weights from memory into the filter buffer, then signals done.
module filter_buf_loader #(
  parameter int unsigned W_CHANNEL       = 8,
  parameter int unsigned W_ADDR          = 32,
  parameter int unsigned W_DATA          = 32,
  parameter int unsigned W_BUF_ADDR      = 10,
  parameter int unsigned FILT_WORDS      = 9,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [W_ADDR-1:0]     q_filter_base,
  input  logic [W_CHANNEL-1:0]  q_channel,
  input  logic                  i_fb_load_req,
  input  logic                  i_ctrl_csync_run,
  input  logic [W_CHANNEL-1:0]  i_chn_out,
  output logic                  o_mem_req,
  output logic [W_ADDR-1:0]     o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [W_DATA-1:0]     i_mem_rdata,
  output logic                  o_fb_we,
  output logic [W_BUF_ADDR-1:0] o_fb_addr,
  output logic [W_DATA-1:0]     o_fb_wdata,
  output logic                  o_bm_csync_done,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int unsigned BYTES = W_DATA / 8;
  localparam int unsigned W_CNT = W_BUF_ADDR + 1;
  localparam int unsigned W_OUT = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t             state;
  logic [W_CNT-1:0]   total_q;
  logic [W_CNT-1:0]   issued;
  logic [W_CNT-1:0]   written;
  logic [W_OUT-1:0]   outstanding;
  logic [W_ADDR-1:0]  addr_q;
  logic               run_lost;

  logic [W_CNT-1:0]   total_c;
  logic [W_ADDR-1:0]  start_addr;
  logic [W_CNT-1:0]   issued_nxt;
  logic               mem_req;
  logic               grant;
  logic               rv_ok;

  always_comb begin
    total_c    = W_CNT'(q_channel * FILT_WORDS);
    start_addr = q_filter_base
               + W_ADDR'(i_chn_out) * W_ADDR'(total_c) * W_ADDR'(BYTES);
    mem_req    = (state == FETCH) && (issued < total_q)
               && (outstanding < W_OUT'(MAX_OUTSTANDING));
    grant      = mem_req && i_mem_gnt;
    // Data with nothing in flight is stale (e.g. from before a reset) and is dropped.
    rv_ok      = i_mem_rvalid && (outstanding != '0);
    issued_nxt = issued + W_CNT'(grant);
  end

  assign o_mem_req  = mem_req;
  assign o_mem_addr = addr_q;
  assign o_busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      total_q         <= '0;
      issued          <= '0;
      written         <= '0;
      outstanding     <= '0;
      addr_q          <= '0;
      run_lost        <= 1'b0;
      o_fb_we         <= 1'b0;
      o_fb_addr       <= '0;
      o_fb_wdata      <= '0;
      o_bm_csync_done <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_fb_we <= rv_ok;
      if (rv_ok) begin
        o_fb_addr  <= written[W_BUF_ADDR-1:0];
        o_fb_wdata <= i_mem_rdata;
        written    <= written + W_CNT'(1);
      end else if (i_mem_rvalid) begin
        o_err <= 1'b1;
      end

      if (grant && !rv_ok)
        outstanding <= outstanding + W_OUT'(1);
      else if (!grant && rv_ok)
        outstanding <= outstanding - W_OUT'(1);

      if (grant) begin
        issued <= issued_nxt;
        addr_q <= addr_q + W_ADDR'(BYTES);
      end

      if (i_fb_load_req && (state != IDLE))
        o_err <= 1'b1;

      // Losing CSYNC mid-load is flagged; the load still finishes but DONE is left at once.
      if (!i_ctrl_csync_run && ((state == FETCH) || (state == DRAIN))) begin
        o_err    <= 1'b1;
        run_lost <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (i_fb_load_req) begin
            total_q  <= total_c;
            addr_q   <= start_addr;
            issued   <= '0;
            written  <= '0;
            run_lost <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (total_q == '0) begin
            state           <= DONE;
            o_bm_csync_done <= 1'b1;
          end else if (issued_nxt == total_q) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (written == total_q) begin
            state           <= DONE;
            o_bm_csync_done <= 1'b1;
          end
        end
        DONE: begin
          if (!i_ctrl_csync_run || run_lost) begin
            state           <= IDLE;
            o_bm_csync_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
